game_status_tracker: RTL and testbench

Produces the `Win` and `loss` level signals consumed by the top-level game controller. It takes back the controller's 2-bit `state` code as `game_state` and runs only while that code is Level (`2'b01`). It turns per-frame gameplay events into score, lives, pellet count, power-mode and death/respawn sequencing. It sits between the sprite/collision logic and the game controller, and drives the HUD.

---
 rtl/game_pkg.sv | 31 +++
 rtl/game_status_tracker_if.sv | 26 ++
 rtl/frame_countdown.sv | 30 +++
 rtl/game_status_tracker.sv | 189 ++++++++++++++++++
 tb/tb_game_status_tracker.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: controller state codes, tracker FSM states, point values
// and a saturating score adder.
package game_pkg;

  localparam logic [1:0] GS_START    = 2'b00;
  localparam logic [1:0] GS_LEVEL    = 2'b01;
  localparam logic [1:0] GS_GAMEOVER = 2'b10;
  localparam logic [1:0] GS_YOUWIN   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    POWER,
    DYING,
    WON,
    LOST
  } tracker_state_e;

  localparam int DEF_PELLET_PTS = 10;
  localparam int DEF_POWER_PTS  = 50;
  localparam int DEF_GHOST_PTS  = 200;
  localparam int GHOST_MULT_MAX = 3;

  // Score never wraps: anything past 16'hFFFF pins at 16'hFFFF.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [17:0] b);
    logic [18:0] sum;
    sum = {3'b000, a} + {1'b0, b};
    return (sum > 19'h0FFFF) ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/game_status_tracker_if.sv
// Event/status bundle between the sprite/collision side, the game controller
// and the status tracker.
interface game_status_tracker_if;
  logic [1:0]  game_state;
  logic        frame_tick;
  logic        pellet_eaten;
  logic        power_eaten;
  logic        ghost_hit;
  logic        Win;
  logic        loss;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [8:0]  pellets_left;
  logic        power_mode;
  logic        respawn_req;

  modport master (
    output game_state, frame_tick, pellet_eaten, power_eaten, ghost_hit,
    input  Win, loss, score, lives, pellets_left, power_mode, respawn_req
  );

  modport slave (
    input  game_state, frame_tick, pellet_eaten, power_eaten, ghost_hit,
    output Win, loss, score, lives, pellets_left, power_mode, respawn_req
  );
endinterface

// File: rtl/frame_countdown.sv
// Loadable frame down-counter shared by power mode and the death animation.
// done_o flags the frame_tick that brings (or finds) the count at zero.
module frame_countdown #(
  parameter int WIDTH = 9
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge Clk) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  // Combinational so the owner can leave its state on the same edge the count hits zero.
  assign done_o = tick_i && (count_q <= WIDTH'(1));

endmodule

// File: rtl/game_status_tracker.sv
// Turns per-frame gameplay events into score, lives, pellet count, power mode and
// death/respawn sequencing; reports Win/loss back to the game controller.
module game_status_tracker
  import game_pkg::*;
#(
  parameter int TOTAL_PELLETS = 244,
  parameter int START_LIVES   = 3,
  parameter int POWER_FRAMES  = 360,
  parameter int DEATH_FRAMES  = 90,
  parameter int PELLET_PTS    = DEF_PELLET_PTS,
  parameter int POWER_PTS     = DEF_POWER_PTS,
  parameter int GHOST_PTS     = DEF_GHOST_PTS
) (
  input  logic                  Clk,
  input  logic                  reset,
  game_status_tracker_if.slave  bus
);

  localparam logic [8:0] PELLETS_INIT = 9'(TOTAL_PELLETS);
  localparam logic [1:0] LIVES_INIT   = 2'(START_LIVES);
  localparam logic [8:0] POWER_LOAD   = 9'(POWER_FRAMES);
  localparam logic [8:0] DEATH_LOAD   = 9'(DEATH_FRAMES);

  tracker_state_e state_q, state_d;
  logic [15:0]    score_q, score_d;
  logic [1:0]     lives_q, lives_d;
  logic [8:0]     pellets_q, pellets_d;
  logic [1:0]     mult_q, mult_d;
  logic           win_q, loss_q, power_q;
  logic           respawn_q, respawn_d;

  logic           tmr_clear, tmr_load, tmr_done;
  logic [8:0]     tmr_val;

  logic [1:0]     eaten_cnt;
  logic           any_eat, maze_clear;
  logic [8:0]     pellets_after;
  logic [17:0]    eat_pts, ghost_pts;
  logic [1:0]     eff_mult, mult_bumped;
  logic [15:0]    score_eat, score_eat_ghost;

  // Pellet and power pellet in one cycle count as two pellets; never go below zero.
  assign eaten_cnt     = {1'b0, bus.pellet_eaten} + {1'b0, bus.power_eaten};
  assign any_eat       = |eaten_cnt;
  assign pellets_after = (pellets_q > {7'd0, eaten_cnt}) ? pellets_q - {7'd0, eaten_cnt} : 9'd0;
  assign maze_clear    = any_eat && (pellets_after == 9'd0);

  assign eat_pts = (bus.pellet_eaten ? 18'(PELLET_PTS) : 18'd0)
                 + (bus.power_eaten  ? 18'(POWER_PTS)  : 18'd0);

  // A power pellet eaten alongside a ghost restarts the chain before the ghost is scored.
  assign eff_mult        = bus.power_eaten ? 2'd0 : mult_q;
  assign mult_bumped     = (eff_mult == 2'(GHOST_MULT_MAX)) ? eff_mult : eff_mult + 2'd1;
  assign ghost_pts       = 18'(GHOST_PTS) << eff_mult;
  assign score_eat       = sat_add16(score_q, eat_pts);
  assign score_eat_ghost = sat_add16(score_q, eat_pts + ghost_pts);

  frame_countdown #(
    .WIDTH(9)
  ) u_frame_countdown (
    .Clk       (Clk),
    .reset     (reset),
    .clear_i   (tmr_clear),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .tick_i    (bus.frame_tick),
    .done_o    (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    pellets_d = pellets_q;
    mult_d    = mult_q;
    respawn_d = 1'b0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = POWER_LOAD;

    case (bus.game_state)
      GS_START: begin
        state_d   = IDLE;
        score_d   = '0;
        lives_d   = LIVES_INIT;
        pellets_d = PELLETS_INIT;
        mult_d    = '0;
        tmr_clear = 1'b1;
      end

      GS_GAMEOVER, GS_YOUWIN: begin
        if (state_q == PLAY || state_q == POWER || state_q == DYING) begin
          state_d = IDLE;
        end
      end

      GS_LEVEL: begin
        case (state_q)
          IDLE: state_d = PLAY;

          // A ghost hit here is resolved as a death even if a power pellet lands in
          // the same cycle: the overlap happened before power mode existed.
          PLAY: begin
            pellets_d = pellets_after;
            score_d   = score_eat;
            if (maze_clear) begin
              state_d = WON;
            end else if (bus.ghost_hit) begin
              lives_d  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
              tmr_load = 1'b1;
              tmr_val  = DEATH_LOAD;
              state_d  = DYING;
            end else if (bus.power_eaten) begin
              tmr_load = 1'b1;
              tmr_val  = POWER_LOAD;
              mult_d   = '0;
              state_d  = POWER;
            end
          end

          POWER: begin
            pellets_d = pellets_after;
            if (maze_clear) begin
              score_d = score_eat;
              state_d = WON;
            end else begin
              score_d = bus.ghost_hit ? score_eat_ghost : score_eat;
              mult_d  = bus.ghost_hit ? mult_bumped : eff_mult;
              if (bus.power_eaten) begin
                tmr_load = 1'b1;
                tmr_val  = POWER_LOAD;
              end else if (tmr_done) begin
                state_d = PLAY;
              end
            end
          end

          DYING: begin
            if (tmr_done) begin
              if (lives_q == 2'd0) begin
                state_d = LOST;
              end else begin
                state_d   = PLAY;
                respawn_d = 1'b1;
              end
            end
          end

          default: ;
        endcase
      end

      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= IDLE;
      score_q   <= '0;
      lives_q   <= LIVES_INIT;
      pellets_q <= PELLETS_INIT;
      mult_q    <= '0;
      win_q     <= 1'b0;
      loss_q    <= 1'b0;
      power_q   <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      pellets_q <= pellets_d;
      mult_q    <= mult_d;
      win_q     <= (state_d == WON);
      loss_q    <= (state_d == LOST);
      power_q   <= (state_d == POWER);
      respawn_q <= respawn_d;
    end
  end

  assign bus.Win          = win_q;
  assign bus.loss         = loss_q;
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.pellets_left = pellets_q;
  assign bus.power_mode   = power_q;
  assign bus.respawn_req  = respawn_q;

endmodule

// File: tb/tb_game_status_tracker.sv
// Scoreboard bench: driver applies one vector per cycle and queues the reference
// model's expected outputs; a monitor pops and compares after every clock edge.
module tb_game_status_tracker;
  import game_pkg::*;

  localparam int TB_TOTAL  = 40;
  localparam int TB_LIVES  = 3;
  localparam int TB_POWERF = 12;
  localparam int TB_DEATHF = 5;
  localparam int TB_PELLET = 10;
  localparam int TB_POWPTS = 50;
  localparam int TB_GHOST  = 200;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  always #5 Clk = ~Clk;

  game_status_tracker_if bus ();

  game_status_tracker #(
    .TOTAL_PELLETS(TB_TOTAL),
    .START_LIVES  (TB_LIVES),
    .POWER_FRAMES (TB_POWERF),
    .DEATH_FRAMES (TB_DEATHF),
    .PELLET_PTS   (TB_PELLET),
    .POWER_PTS    (TB_POWPTS),
    .GHOST_PTS    (TB_GHOST)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit win;
    bit loss;
    int score;
    int lives;
    int pellets;
    bit power;
    bit respawn;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: game phase, counters as plain integers.
  typedef enum int {M_OFF, M_NORMAL, M_FRIGHT, M_DEAD, M_VICTORY, M_DEFEAT} mmode_e;
  mmode_e m_mode = M_OFF;
  int m_score, m_lives, m_pellets, m_chain, m_frames;
  bit m_respawn;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_init();
    m_score   = 0;
    m_lives   = TB_LIVES;
    m_pellets = TB_TOTAL;
    m_chain   = 0;
    m_frames  = 0;
    m_mode    = M_OFF;
  endtask

  task automatic model_step(input logic [1:0] gs, input bit tick, input bit pel,
                            input bit pow, input bit gh, input bit rst);
    int eaten, left, pts, k;
    m_respawn = 0;
    eaten = int'(pel) + int'(pow);
    left  = m_pellets - eaten;
    if (left < 0) left = 0;
    pts   = TB_PELLET * int'(pel) + TB_POWPTS * int'(pow);
    if (rst || gs == GS_START) begin
      model_init();
    end else if (gs != GS_LEVEL) begin
      if (m_mode == M_NORMAL || m_mode == M_FRIGHT || m_mode == M_DEAD) m_mode = M_OFF;
    end else begin
      case (m_mode)
        M_OFF: m_mode = M_NORMAL;
        M_NORMAL, M_FRIGHT: begin
          if (eaten > 0 && left == 0) begin
            m_pellets = 0;
            m_score   = sat(m_score + pts);
            m_mode    = M_VICTORY;
          end else if (m_mode == M_NORMAL) begin
            m_pellets = left;
            m_score   = sat(m_score + pts);
            if (gh) begin
              if (m_lives > 0) m_lives--;
              m_frames = TB_DEATHF;
              m_mode   = M_DEAD;
            end else if (pow) begin
              m_frames = TB_POWERF;
              m_chain  = 0;
              m_mode   = M_FRIGHT;
            end
          end else begin
            if (pow) m_chain = 0;
            if (gh) begin
              k = (m_chain > 3) ? 3 : m_chain;
              pts += TB_GHOST * (1 << k);
              m_chain++;
            end
            m_pellets = left;
            m_score   = sat(m_score + pts);
            if (pow) m_frames = TB_POWERF;
            else if (tick) begin
              m_frames--;
              if (m_frames <= 0) begin
                m_frames = 0;
                m_mode   = M_NORMAL;
              end
            end
          end
        end
        M_DEAD: begin
          if (tick) begin
            m_frames--;
            if (m_frames <= 0) begin
              m_frames = 0;
              if (m_lives == 0) m_mode = M_DEFEAT;
              else begin
                m_mode    = M_NORMAL;
                m_respawn = 1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic [1:0] gs, input bit tick, input bit pel,
                       input bit pow, input bit gh, input bit rst);
    exp_t e;
    @(negedge Clk);
    reset            = rst;
    bus.game_state   = gs;
    bus.frame_tick   = tick;
    bus.pellet_eaten = pel;
    bus.power_eaten  = pow;
    bus.ghost_hit    = gh;
    model_step(gs, tick, pel, pow, gh, rst);
    e.win     = (m_mode == M_VICTORY);
    e.loss    = (m_mode == M_DEFEAT);
    e.score   = m_score;
    e.lives   = m_lives;
    e.pellets = m_pellets;
    e.power   = (m_mode == M_FRIGHT);
    e.respawn = m_respawn;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [1:0] gs, input int n);
    for (int i = 0; i < n; i++) drive(gs, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every edge with a queued expectation is one vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.Win !== e.win || bus.loss !== e.loss || bus.score !== 16'(e.score) ||
            bus.lives !== 2'(e.lives) || bus.pellets_left !== 9'(e.pellets) ||
            bus.power_mode !== e.power || bus.respawn_req !== e.respawn) begin
          n_miss++;
          $display("FAIL vec%0d t=%0t: got Win=%0b loss=%0b score=%0d lives=%0d pellets=%0d power=%0b respawn=%0b; need Win=%0b loss=%0b score=%0d lives=%0d pellets=%0d power=%0b respawn=%0b",
                   n_vec, $time, bus.Win, bus.loss, bus.score, bus.lives, bus.pellets_left,
                   bus.power_mode, bus.respawn_req, e.win, e.loss, e.score, e.lives,
                   e.pellets, e.power, e.respawn);
        end
      end
    end
  end

  initial begin
    int r;
    bit rst_r;
    logic [1:0] gs_r;
    bus.game_state   = GS_START;
    bus.frame_tick   = 0;
    bus.pellet_eaten = 0;
    bus.power_eaten  = 0;
    bus.ghost_hit    = 0;

    // Reset state
    drive(GS_START, 0, 0, 0, 0, 1);
    drive(GS_START, 0, 0, 0, 0, 1);
    idle(GS_START, 2);

    // Pellet score
    idle(GS_LEVEL, 1);
    for (int i = 0; i < 3; i++) drive(GS_LEVEL, 0, 1, 0, 0, 0);
    idle(GS_LEVEL, 1);

    // Ghost chain, then power mode runs out
    drive(GS_LEVEL, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(GS_LEVEL, 0, 0, 0, 1, 0);
      drive(GS_LEVEL, 1, 0, 0, 0, 0);
    end
    for (int i = 0; i < TB_POWERF; i++) drive(GS_LEVEL, 1, 0, 0, 0, 0);
    idle(GS_LEVEL, 2);

    // Death, respawns, loss, and reinit on Start
    for (int d = 0; d < 3; d++) begin
      drive(GS_LEVEL, 0, 0, 0, 1, 0);
      for (int i = 0; i < TB_DEATHF; i++) drive(GS_LEVEL, 1, 0, 0, 0, 0);
      idle(GS_LEVEL, 1);
    end
    idle(GS_LEVEL, 3);
    idle(GS_START, 2);

    // Win with simultaneous collision
    idle(GS_LEVEL, 1);
    for (int i = 0; i < TB_TOTAL - 1; i++) drive(GS_LEVEL, 0, 1, 0, 0, 0);
    drive(GS_LEVEL, 0, 1, 0, 1, 0);
    idle(GS_LEVEL, 3);
    idle(GS_START, 2);

    // Abort during power mode, then reset mid-death with a pending event
    idle(GS_LEVEL, 1);
    drive(GS_LEVEL, 0, 0, 1, 0, 0);
    drive(GS_LEVEL, 1, 0, 0, 0, 0);
    idle(GS_START, 2);
    idle(GS_LEVEL, 1);
    drive(GS_LEVEL, 0, 1, 0, 1, 0);
    drive(GS_LEVEL, 1, 0, 0, 0, 0);
    drive(GS_LEVEL, 1, 1, 0, 0, 1);
    idle(GS_LEVEL, 2);

    // Score saturation through repeated ghost chains
    idle(GS_START, 2);
    idle(GS_LEVEL, 1);
    for (int c = 0; c < 22; c++) begin
      drive(GS_LEVEL, 0, 0, 1, 0, 0);
      for (int g = 0; g < 4; g++) drive(GS_LEVEL, 0, 0, 0, 1, 0);
    end
    for (int i = 0; i < 3; i++) drive(GS_LEVEL, 0, 1, 0, 0, 0);
    drive(GS_LEVEL, 0, 1, 1, 1, 0);
    idle(GS_LEVEL, 2);
    idle(GS_START, 2);

    // Randomized play
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r < 3) gs_r = GS_START;
      else if (r == 3) gs_r = GS_GAMEOVER;
      else if (r == 4) gs_r = GS_YOUWIN;
      else gs_r = GS_LEVEL;
      rst_r = ($urandom_range(0, 499) == 0);
      drive(gs_r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0), rst_r);
    end
    drive(GS_START, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
